// File: rtl/sd_img_pkg.sv
// rtl/sd_img_pkg.sv - shared SD image path state encoding and frame geometry defaults
package sd_img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_REQ        = 3'd2,
        ST_WAIT_BUSY  = 3'd3,
        ST_XFER       = 3'd4,
        ST_NEXT       = 3'd5
    } sd_img_state_e;

    // 16-bit words carried by one 512-byte sector
    localparam logic [8:0]  WORDS_PER_SECTOR_C      = 9'd256;
    // Stored frame location and length: 1280x800 RGB565 = 4000 sectors
    localparam logic [31:0] BASE_SECTOR_DEF         = 32'd16000;
    localparam logic [12:0] SECTORS_PER_FRAME_DEF   = 13'd4000;

endpackage

// File: rtl/sd_img_reader.sv
// rtl/sd_img_reader.sv - streams one stored frame from sd_ctrl sector reads into pixel strobes
module sd_img_reader
    import sd_img_pkg::*;
#(
    parameter logic [31:0] BASE_SECTOR       = BASE_SECTOR_DEF,
    parameter logic [12:0] SECTORS_PER_FRAME = SECTORS_PER_FRAME_DEF,
    parameter logic [8:0]  WORDS_PER_SECTOR  = WORDS_PER_SECTOR_C,
    parameter logic [15:0] TIMEOUT_CYC       = 16'd50000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        start,
    input  logic        loop_en,
    input  logic        abort,
    input  logic        rd_busy,
    input  logic        rd_data_en,
    input  logic [15:0] rd_data,
    input  logic [11:0] dn_free,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        err
);

    sd_img_state_e state_q, state_d;
    logic [12:0]   sector_cnt_q, sector_cnt_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [8:0]    word_cnt_q, word_cnt_d;
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic          abort_q, abort_d;
    logic          err_q, err_d;
    logic          frame_start_q, frame_start_d;
    logic          pix_valid_q, pix_valid_d;
    logic [15:0]   pix_data_q, pix_data_d;

    logic          more_sectors;
    logic          word_take;
    logic [8:0]    word_cnt_nxt;

    // Words beyond a full sector are dropped rather than forwarded
    assign more_sectors = sector_cnt_q < (SECTORS_PER_FRAME - 13'd1);
    assign word_take    = (state_q == ST_XFER) && rd_data_en && (word_cnt_q < WORDS_PER_SECTOR);
    assign word_cnt_nxt = word_cnt_q + {8'd0, word_take};

    // Next-state, datapath updates and the combinational strobes
    always_comb begin
        state_d       = state_q;
        sector_cnt_d  = sector_cnt_q;
        rd_addr_d     = rd_addr_q;
        word_cnt_d    = word_cnt_q;
        to_cnt_d      = to_cnt_q;
        abort_d       = abort_q;
        err_d         = err_q;
        frame_start_d = 1'b0;
        pix_valid_d   = word_take;
        pix_data_d    = word_take ? rd_data : pix_data_q;
        rd_en         = 1'b0;
        frame_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort && start && init_end) begin
                    sector_cnt_d  = 13'd0;
                    rd_addr_d     = BASE_SECTOR;
                    err_d         = 1'b0;
                    frame_start_d = 1'b1;
                    state_d       = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if ((dn_free >= {3'd0, WORDS_PER_SECTOR}) && !rd_busy) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                rd_en    = 1'b1;
                // Counter starts at 1 so it measures cycles since rd_en
                to_cnt_d = 16'd1;
                abort_d  = abort_q | abort;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                abort_d = abort_q | abort;
                if (rd_busy) begin
                    word_cnt_d = 9'd0;
                    state_d    = ST_XFER;
                end else if (to_cnt_q >= (TIMEOUT_CYC - 16'd1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_XFER: begin
                abort_d    = abort_q | abort;
                word_cnt_d = word_cnt_nxt;
                if (rd_data_en && !word_take) begin
                    err_d = 1'b1;
                end
                if (!rd_busy) begin
                    word_cnt_d = 9'd0;
                    if (word_cnt_nxt == WORDS_PER_SECTOR) begin
                        // A pending abort on the last sector still ends the frame cleanly
                        state_d = (abort_d && more_sectors) ? ST_IDLE : ST_NEXT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_NEXT: begin
                if (more_sectors) begin
                    if (abort_q || abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        sector_cnt_d = sector_cnt_q + 13'd1;
                        rd_addr_d    = rd_addr_q + 32'd1;
                        state_d      = ST_WAIT_SPACE;
                    end
                end else begin
                    frame_done = 1'b1;
                    if (loop_en && !abort_q && !abort) begin
                        sector_cnt_d  = 13'd0;
                        rd_addr_d     = BASE_SECTOR;
                        frame_start_d = 1'b1;
                        state_d       = ST_WAIT_SPACE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            abort_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            sector_cnt_q  <= 13'd0;
            rd_addr_q     <= BASE_SECTOR;
            word_cnt_q    <= 9'd0;
            to_cnt_q      <= 16'd0;
            abort_q       <= 1'b0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 16'h0;
        end else begin
            state_q       <= state_d;
            sector_cnt_q  <= sector_cnt_d;
            rd_addr_q     <= rd_addr_d;
            word_cnt_q    <= word_cnt_d;
            to_cnt_q      <= to_cnt_d;
            abort_q       <= abort_d;
            err_q         <= err_d;
            frame_start_q <= frame_start_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_sd_img_reader.sv
// tb/tb_sd_img_reader.sv - directed self-checking bench for sd_img_reader
module tb_sd_img_reader;

    logic        clk = 1'b0;
    logic        rst_n, init_end, start, start2, loop_en, abort;
    logic        rd_busy, rd_data_en;
    logic [15:0] rd_data;
    logic [11:0] dn_free;

    logic        rd_en1, pix_valid1, frame_start1, frame_done1, busy1, err1;
    logic [31:0] rd_addr1;
    logic [15:0] pix_data1;
    logic        rd_en2, pix_valid2, frame_start2, frame_done2, busy2, err2;
    logic [31:0] rd_addr2;
    logic [15:0] pix_data2;

    logic        sel;
    int          mdl_words;
    logic        mdl_nobusy;

    int          n_asrt = 0;
    int          n_fail = 0;
    int          clr_gen = 0;
    int          rd_en_cnt = 0, pix_cnt = 0, fs_cnt = 0, fd_cnt = 0, px_bad = 0;
    logic [31:0] addr_log [8];

    logic        m_rd_en, m_pix_valid, m_frame_start, m_frame_done, m_busy;
    logic [31:0] m_rd_addr;
    logic [15:0] m_pix_data;

    always #5 clk = ~clk;

    sd_img_reader #(.SECTORS_PER_FRAME(13'd3), .TIMEOUT_CYC(16'd100)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end), .start(start),
        .loop_en(loop_en), .abort(abort), .rd_busy(rd_busy), .rd_data_en(rd_data_en),
        .rd_data(rd_data), .dn_free(dn_free), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .pix_valid(pix_valid1), .pix_data(pix_data1), .frame_start(frame_start1),
        .frame_done(frame_done1), .busy(busy1), .err(err1)
    );

    sd_img_reader #(.SECTORS_PER_FRAME(13'd2), .TIMEOUT_CYC(16'd100)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end), .start(start2),
        .loop_en(loop_en), .abort(abort), .rd_busy(rd_busy), .rd_data_en(rd_data_en),
        .rd_data(rd_data), .dn_free(dn_free), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .pix_valid(pix_valid2), .pix_data(pix_data2), .frame_start(frame_start2),
        .frame_done(frame_done2), .busy(busy2), .err(err2)
    );

    assign m_rd_en       = sel ? rd_en2       : rd_en1;
    assign m_rd_addr     = sel ? rd_addr2     : rd_addr1;
    assign m_pix_valid   = sel ? pix_valid2   : pix_valid1;
    assign m_pix_data    = sel ? pix_data2    : pix_data1;
    assign m_frame_start = sel ? frame_start2 : frame_start1;
    assign m_frame_done  = sel ? frame_done2  : frame_done1;
    assign m_busy        = sel ? busy2        : busy1;

    // sd_ctrl model: answers a rd_en with rd_busy, mdl_words strobes, then drops rd_busy
    initial begin
        logic [31:0] a;
        rd_busy = 1'b0; rd_data_en = 1'b0; rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (m_rd_en && !mdl_nobusy) begin
                a = m_rd_addr;
                @(posedge clk); #1 rd_busy = 1'b1;
                for (int i = 0; i < mdl_words; i++) begin
                    @(posedge clk); #1;
                    rd_data_en = 1'b1;
                    rd_data    = {a[7:0], 8'(i)};
                end
                @(posedge clk); #1;
                rd_data_en = 1'b0;
                rd_busy    = 1'b0;
            end
        end
    end

    // Event monitor: pixel data must equal the strobe word of the previous cycle
    initial begin
        int          seen_gen;
        logic        prev_en;
        logic [15:0] prev_data;
        seen_gen = 0; prev_en = 1'b0; prev_data = 16'h0;
        forever begin
            @(negedge clk);
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                rd_en_cnt = 0; pix_cnt = 0; fs_cnt = 0; fd_cnt = 0; px_bad = 0;
            end
            if (m_rd_en) begin
                if (rd_en_cnt < 8) addr_log[rd_en_cnt] = m_rd_addr;
                rd_en_cnt++;
            end
            if (m_pix_valid) begin
                pix_cnt++;
                if (!(prev_en && m_pix_data == prev_data)) px_bad++;
            end
            if (m_frame_start) fs_cnt++;
            if (m_frame_done)  fd_cnt++;
            prev_en   = rd_data_en;
            prev_data = rd_data;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        clr_gen++;
        tick();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!m_busy) begin ok = 1'b1; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        logic found;
        logic err_early;
        rst_n = 1'b0; init_end = 1'b0; start = 1'b0; start2 = 1'b0;
        loop_en = 1'b0; abort = 1'b0; dn_free = 12'd4095;
        sel = 1'b0; mdl_words = 256; mdl_nobusy = 1'b0;
        repeat (3) tick();
        check("rst_ctl", {26'd0, rd_en1, pix_valid1, frame_start1, frame_done1, busy1, err1}, 0);
        check("rst_pix", {16'd0, pix_data1}, 0);
        check("rst_addr", rd_addr1, 32'd16000);
        rst_n = 1'b1;
        tick();

        // start without init_end is ignored
        pulse_start(); tick();
        check("start_no_init", busy1, 0);
        init_end = 1'b1;

        // one full 3-sector frame
        clear();
        pulse_start();
        check("fs_pulse", frame_start1, 1);
        check("busy_on", busy1, 1);
        wait_idle(3000, "frame_end");
        check("frame_rd_en", rd_en_cnt, 3);
        check("frame_addr0", addr_log[0], 32'd16000);
        check("frame_addr1", addr_log[1], 32'd16001);
        check("frame_addr2", addr_log[2], 32'd16002);
        check("frame_pix", pix_cnt, 768);
        check("frame_pix_data", px_bad, 0);
        check("frame_fs", fs_cnt, 1);
        check("frame_fd", fd_cnt, 1);
        check("frame_err", err1, 0);

        // downstream back-pressure, plus a start while busy
        clear();
        dn_free = 12'd100;
        pulse_start();
        repeat (20) tick();
        pulse_start();
        repeat (29) tick();
        check("bp_no_rd_en", rd_en_cnt, 0);
        check("bp_busy", busy1, 1);
        dn_free = 12'd300;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rd_en1) begin found = 1'b1; break; end
        end
        check("bp_rd_en_prompt", found, 1);
        wait_idle(3000, "bp_end");
        check("bp_fs_once", fs_cnt, 1);
        check("bp_rd_en_cnt", rd_en_cnt, 3);
        check("bp_err", err1, 0);

        // short sector
        clear();
        mdl_words = 255;
        pulse_start();
        wait_idle(1000, "short_end");
        check("short_err", err1, 1);
        check("short_fd", fd_cnt, 0);
        check("short_rd_en", rd_en_cnt, 1);
        check("short_pix", pix_cnt, 255);
        mdl_words = 256;

        // rd_busy never rises
        clear();
        mdl_nobusy = 1'b1;
        pulse_start();
        check("to_err_cleared", err1, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en1) begin found = 1'b1; break; end
            tick();
        end
        check("to_rd_en_seen", found, 1);
        err_early = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (err1) err_early = 1'b1;
        end
        check("to_not_early", err_early, 0);
        tick();
        check("to_err", err1, 1);
        check("to_busy", busy1, 0);
        mdl_nobusy = 1'b0;

        // abort during sector 1 word 10
        clear();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (pix_cnt >= 266) begin found = 1'b1; break; end
        end
        check("ab_reach", found, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rd_busy) begin found = 1'b1; break; end
            tick();
        end
        check("ab_busy_fall", found, 1);
        tick();
        check("ab_idle", busy1, 0);
        repeat (20) tick();
        check("ab_rd_en", rd_en_cnt, 2);
        check("ab_pix", pix_cnt, 512);
        check("ab_pix_data", px_bad, 0);
        check("ab_fd", fd_cnt, 0);
        check("ab_err", err1, 0);

        // looping 2-sector frame, then reset mid-transfer
        sel = 1'b1;
        loop_en = 1'b1;
        clear();
        start2 = 1'b1; tick(); start2 = 1'b0;
        check("lp_fs_first", frame_start2, 1);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (frame_done2) begin found = 1'b1; break; end
        end
        check("lp_fd", found, 1);
        check("lp_rd_en", rd_en_cnt, 2);
        check("lp_addr1", addr_log[1], 32'd16001);
        tick();
        check("lp_fs_again", frame_start2, 1);
        check("lp_addr_reload", rd_addr2, 32'd16000);
        check("lp_fs_cnt", fs_cnt, 2);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pix_cnt >= 517) begin found = 1'b1; break; end
        end
        check("lp_second_xfer", found, 1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_ctl", {26'd0, rd_en2, pix_valid2, frame_start2, frame_done2, busy2, err2}, 0);
        check("rst_mid_pix", {16'd0, pix_data2}, 0);
        check("rst_mid_addr", rd_addr2, 32'd16000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_img_reader.md
SD_IMG_READER -- requirements
Module: sd_img_reader

Interface
REQ-001 SHALL have parameter BASE_SECTOR, default 32'd16000: first SD sector of the stored frame.
REQ-002 SHALL have parameter SECTORS_PER_FRAME, default 13'd4000: 1280x800 pixels x 16 bit / 256 words per sector.
REQ-003 SHALL have parameter WORDS_PER_SECTOR, default 9'd256: 16-bit words returned per sector read.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16'd50000: maximum wait for rd_busy to assert after rd_en.
REQ-005 SHALL have port sys_clk, input, 1: 50 MHz clock, same domain as sd_ctrl.
REQ-006 SHALL have port sys_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port init_end, input, 1: SD card initialised.
REQ-008 SHALL have port start, input, 1: one-cycle request to play back one frame.
REQ-009 SHALL have port loop_en, input, 1: restart the frame automatically after frame_done.
REQ-010 SHALL have port abort, input, 1: stop playback.
REQ-011 SHALL have port rd_busy, input, 1: sd_ctrl read in progress.
REQ-012 SHALL have port rd_data_en, input, 1: rd_data valid strobe.
REQ-013 SHALL have port rd_data, input, 16: sector data word.
REQ-014 SHALL have port dn_free, input, 12: free words in the downstream pixel FIFO.
REQ-015 SHALL have port rd_en, output, 1: one-cycle sector read request to sd_ctrl.
REQ-016 SHALL have port rd_addr, output, 32: sector address.
REQ-017 SHALL have port pix_valid, output, 1: pixel strobe.
REQ-018 SHALL have port pix_data, output, 16: RGB565 pixel.
REQ-019 SHALL have port frame_start, output, 1: one-cycle pulse marking the start of a frame.
REQ-020 SHALL have port frame_done, output, 1: one-cycle pulse marking the end of a frame.
REQ-021 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-022 SHALL have port err, output, 1: sticky error flag; cleared only by the next accepted start.

Function
REQ-023 States SHALL be IDLE, WAIT_SPACE, REQ, WAIT_BUSY, XFER, NEXT.
REQ-024 In IDLE, start=1 with init_end=1 SHALL load sector_cnt=0 and rd_addr=BASE_SECTOR, clear err, pulse frame_start on the next cycle, and go to WAIT_SPACE; start with init_end=0 SHALL be ignored.
REQ-025 WAIT_SPACE SHALL advance to REQ only when dn_free>=WORDS_PER_SECTOR and rd_busy=0.
REQ-026 REQ SHALL drive rd_en=1 for exactly one cycle and then go to WAIT_BUSY.
REQ-027 rd_addr SHALL remain stable from REQ until the XFER exit.
REQ-028 WAIT_BUSY SHALL go to XFER on rd_busy=1.
REQ-029 If rd_busy stays low for TIMEOUT_CYC cycles in WAIT_BUSY, the block SHALL set err and go to IDLE.
REQ-030 In XFER, each rd_data_en=1 SHALL produce pix_valid=1 with pix_data=rd_data exactly one cycle later, and SHALL increment a 9-bit word_cnt.
REQ-031 Strobes arriving after word_cnt==WORDS_PER_SECTOR SHALL be dropped, produce no pix_valid, and set err.
REQ-032 On rd_busy falling in XFER: word_cnt==WORDS_PER_SECTOR SHALL go to NEXT; any other count SHALL set err and go to IDLE. word_cnt SHALL clear on exit.
REQ-033 NEXT, if sector_cnt<SECTORS_PER_FRAME-1, SHALL increment sector_cnt and rd_addr and go to WAIT_SPACE.
REQ-034 NEXT on the last sector SHALL pulse frame_done, then:
- with loop_en=1, reload BASE_SECTOR and go to WAIT_SPACE, with frame_start pulsed on the following cycle;
- otherwise go to IDLE.
REQ-035 rd_addr arithmetic SHALL be 32-bit modulo 2^32; it wraps without an error.
REQ-036 abort in IDLE or WAIT_SPACE SHALL take effect next cycle (go to IDLE, no frame_done).
REQ-037 abort in REQ, WAIT_BUSY or XFER SHALL be latched and honoured at the sector boundary (XFER exit), so sd_ctrl is never cut mid-sector; the latch SHALL clear on entering IDLE.
REQ-038 start while busy=1 SHALL be ignored.
REQ-039 When abort and the last-sector NEXT occur together, frame_done SHALL pulse and the next state SHALL be IDLE regardless of loop_en.

Reset
REQ-040 Asserting sys_rst_n=0 at any time, including mid-sector, SHALL force state IDLE and all outputs to 0: rd_en, pix_valid, pix_data=16'h0, frame_start, frame_done, busy, err.
REQ-041 Reset SHALL also force rd_addr=BASE_SECTOR and clear sector_cnt, word_cnt, the timeout counter and the abort latch.

Structure
REQ-042 The state encoding, WORDS_PER_SECTOR and the default BASE_SECTOR/SECTORS_PER_FRAME SHALL live in shared package sd_img_pkg, which sd_img_reader and the existing SD write path both use.
REQ-043 The design SHALL be a single module with no sub-module; the timeout counter stays inline.

Verification
REQ-044 Bench SHALL cover: SECTORS_PER_FRAME=3, start, sd model returns 256 words/sector -> 3 rd_en pulses at addr 16000/16001/16002, 768 pix_valid, one frame_start, one frame_done, err=0.
REQ-045 Bench SHALL cover: dn_free=100 then 300 after 50 cycles -> no rd_en while dn_free=100; rd_en within 2 cycles of dn_free=300.
REQ-046 Bench SHALL cover: model returns 255 words then drops rd_busy -> err=1, state IDLE, no frame_done.
REQ-047 Bench SHALL cover: model never raises rd_busy, TIMEOUT_CYC=100 -> err=1 at cycle 100 after rd_en, busy=0.
REQ-048 Bench SHALL cover: abort at word 10 of sector 1 -> 256 words of sector 1 still forwarded, no further rd_en, busy=0 after rd_busy falls.
REQ-049 Bench SHALL cover: loop_en=1, SECTORS_PER_FRAME=2 -> frame_done then frame_start, rd_addr back to 16000; sys_rst_n=0 mid-XFER -> all outputs 0 next cycle.
